// File: rtl/fpnew_pkg.sv
// Shared FPU types: operation groups and IEEE exception flag bundle.
package fpnew_pkg;

   localparam int unsigned NUM_OPGROUPS = 4;
   localparam int unsigned OPGROUP_BITS = 2;

   typedef enum logic [OPGROUP_BITS-1:0] {
      ADDMUL,
      DIVSQRT,
      NONCOMP,
      CONV
   } opgroup_e;

   // Field order matches the RISC-V fflags CSR layout (NV is bit 4).
   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   // Bitwise OR of two flag sets, used wherever results from several sources are merged.
   function automatic status_t merge_status(status_t a, status_t b);
      return status_t'(a | b);
   endfunction

endpackage

// File: rtl/fpnew_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or above prio, wrapping.
module fpnew_rr_arb #(
   parameter  int unsigned NumInp   = 4,
   localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic [NumInp-1:0]   req,
   input  logic [IdxWidth-1:0] prio,
   input  logic                en,
   output logic [NumInp-1:0]   gnt,
   output logic [IdxWidth-1:0] gnt_idx
);

   logic        w_found;
   int unsigned w_idx;

   // Scan requests starting at the priority pointer; the first hit wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         w_idx = (32'(prio) + i) % NumInp;
         if (en && !w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            gnt_idx    = IdxWidth'(w_idx);
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpnew_opgroup_result_arbiter.sv
// Merges operation-group results onto the single FPU output port through a
// one-entry registered stage, and accumulates sticky exception flags.
module fpnew_opgroup_result_arbiter
   import fpnew_pkg::*;
#(
   parameter  int unsigned Width    = 64,
   parameter  int unsigned TagWidth = 8,
   parameter  int unsigned NumInp   = NUM_OPGROUPS,
   localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic [NumInp-1:0]   in_valid_i,
   output logic [NumInp-1:0]   in_ready_o,
   input  logic [Width-1:0]    in_result_i [NumInp],
   input  status_t             in_status_i [NumInp],
   input  logic [TagWidth-1:0] in_tag_i    [NumInp],
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [Width-1:0]    result_o,
   output status_t             status_o,
   output logic [TagWidth-1:0] tag_o,
   output opgroup_e            opgrp_o,
   input  logic                fflags_clr_i,
   output status_t             fflags_o,
   output logic                busy_o
);

   logic                r_out_valid;
   logic [Width-1:0]    r_result;
   status_t             r_status;
   logic [TagWidth-1:0] r_tag;
   opgroup_e            r_opgrp;
   logic [IdxWidth-1:0] r_prio;
   status_t             r_fflags;

   logic                w_slot_free;
   logic                w_arb_en;
   logic [NumInp-1:0]   w_gnt;
   logic [IdxWidth-1:0] w_gnt_idx;
   logic                w_in_hs;
   logic                w_out_hs;

   // Reset also gates the grant so nothing is consumed while the stage is being cleared.
   assign w_slot_free = !r_out_valid || out_ready_i;
   assign w_arb_en    = w_slot_free && !flush_i && !rst_i;
   // Grant only goes to valid inputs, so any grant bit is a completed input handshake.
   assign w_in_hs     = |w_gnt;
   // A flushed result is discarded, not delivered, so it never counts as a handshake.
   assign w_out_hs    = r_out_valid && out_ready_i && !flush_i;

   fpnew_rr_arb #(
      .NumInp (NumInp)
   ) u_rr_arb (
      .req     (in_valid_i),
      .prio    (r_prio),
      .en      (w_arb_en),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   // Output stage: load on grant, drop on flush or on a drained handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_status    <= '0;
         r_tag       <= '0;
         r_opgrp     <= ADDMUL;
      end else if (flush_i) begin
         r_out_valid <= 1'b0;
      end else if (w_in_hs) begin
         r_out_valid <= 1'b1;
         r_result    <= in_result_i[w_gnt_idx];
         r_status    <= in_status_i[w_gnt_idx];
         r_tag       <= in_tag_i[w_gnt_idx];
         r_opgrp     <= opgroup_e'(OPGROUP_BITS'(w_gnt_idx));
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Priority pointer moves just past the last winner; idle cycles leave it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_prio <= '0;
      end else if (w_in_hs) begin
         if (w_gnt_idx == IdxWidth'(NumInp - 1)) begin
            r_prio <= '0;
         end else begin
            r_prio <= w_gnt_idx + IdxWidth'(1);
         end
      end
   end

   // Sticky flags: clear applies first so a same-cycle delivery survives the clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fflags <= '0;
      end else begin
         r_fflags <= merge_status(fflags_clr_i ? status_t'('0) : r_fflags,
                                  w_out_hs ? r_status : status_t'('0));
      end
   end

   assign in_ready_o  = w_gnt;
   assign out_valid_o = r_out_valid;
   assign result_o    = r_result;
   assign status_o    = r_status;
   assign tag_o       = r_tag;
   assign opgrp_o     = r_opgrp;
   assign fflags_o    = r_fflags;
   assign busy_o      = r_out_valid;

endmodule

// File: tb/tb_fpnew_opgroup_result_arbiter.sv
// Bench for the operation-group result arbiter: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_fpnew_opgroup_result_arbiter;
   import fpnew_pkg::*;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int TW = 8;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [N-1:0]  v;
   logic [N-1:0]  in_ready;
   logic [W-1:0]  res [N];
   status_t       st  [N];
   logic [TW-1:0] tg  [N];
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   status_t       status;
   logic [TW-1:0] tag;
   opgroup_e      opgrp;
   logic          clr;
   status_t       fflags;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;
   int last_g   = -1;

   // Model of the architectural state
   bit            m_valid;
   logic [W-1:0]  m_result;
   status_t       m_status;
   logic [TW-1:0] m_tag;
   opgroup_e      m_opgrp;
   int            m_prio;
   status_t       m_fflags;

   fpnew_opgroup_result_arbiter #(
      .Width    (W),
      .TagWidth (TW),
      .NumInp   (N)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .in_valid_i   (v),
      .in_ready_o   (in_ready),
      .in_result_i  (res),
      .in_status_i  (st),
      .in_tag_i     (tg),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .result_o     (result),
      .status_o     (status),
      .tag_o        (tag),
      .opgrp_o      (opgrp),
      .fflags_clr_i (clr),
      .fflags_o     (fflags),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Winner this cycle according to the rules: -1 when nothing is granted.
   function automatic int model_grant();
      if (rst || flush) return -1;
      if (m_valid && !out_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (v[(m_prio + k) % N]) return (m_prio + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_update(int g);
      bit delivered;
      if (rst) begin
         m_valid  = 0;
         m_result = '0;
         m_status = '0;
         m_tag    = '0;
         m_opgrp  = ADDMUL;
         m_prio   = 0;
         m_fflags = '0;
         return;
      end
      delivered = m_valid && out_ready && !flush;
      m_fflags  = clr ? status_t'('0) : m_fflags;
      if (delivered) m_fflags = status_t'(m_fflags | m_status);
      if (g >= 0) begin
         m_valid  = 1;
         m_result = res[g];
         m_status = st[g];
         m_tag    = tg[g];
         m_opgrp  = opgroup_e'(2'(g));
         m_prio   = (g + 1) % N;
      end else if (flush || delivered) begin
         m_valid = 0;
      end
   endfunction

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic tick();
      int g;
      g = model_grant();
      @(posedge clk);
      model_update(g);
      last_g = g;
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      flush = 1'b0;
      clr   = 1'b0;
      v     = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      rst       = 1'b1;
      v         = 4'b1111;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000)
         $display("FAIL reset_ready: got %b expected 0000", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, busy, result, status, tag, opgrp, fflags} !== {1'b0, 1'b0, 64'h0, 5'b0, 8'h0, ADDMUL, 5'b0})
         $display("FAIL reset_values: got v=%b b=%b r=%h s=%b t=%h o=%0d f=%b expected all zero",
                  out_valid, busy, result, status, tag, opgrp, fflags);
      else n_pass++;
      rst = 1'b0;
      v   = '0;
      tick();
   endtask

   task automatic test_two_inputs();
      do_reset();
      out_ready = 1'b1;
      v      = 4'b1010;
      res[1] = 64'h1111_0000_0000_0001;
      res[3] = 64'h3333_0000_0000_0003;
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) $display("FAIL two_grant0: got %b expected 0010", in_ready);
      else n_pass++;
      tick();
      v = 4'b1000;
      #1;
      n_checks++;
      if (opgrp !== DIVSQRT || result !== 64'h1111_0000_0000_0001 || out_valid !== 1'b1)
         $display("FAIL two_out0: got o=%0d r=%h v=%b expected o=1 r=1111000000000001 v=1",
                  opgrp, result, out_valid);
      else n_pass++;
      n_checks++;
      if (in_ready !== 4'b1000) $display("FAIL two_grant1: got %b expected 1000", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (opgrp !== CONV || result !== 64'h3333_0000_0000_0003)
         $display("FAIL two_out1: got o=%0d r=%h expected o=3 r=3333000000000003", opgrp, result);
      else n_pass++;
      // Pointer back at 0: with inputs 0 and 1 both valid, 0 wins.
      v = 4'b0011;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) $display("FAIL two_prio_wrap: got %b expected 0001", in_ready);
      else n_pass++;
      tick();
      v = '0;
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      out_ready = 1'b1;
      v = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 4'(1 << (k % N)))
            $display("FAIL fair_grant%0d: got %b expected %b", k, in_ready, 4'(1 << (k % N)));
         else n_pass++;
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || opgrp !== opgroup_e'(2'(k % N)))
            $display("FAIL fair_out%0d: got v=%b o=%0d expected v=1 o=%0d", k, out_valid, opgrp, k % N);
         else n_pass++;
      end
      v = '0;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      v     = 4'b0001;
      tg[0] = 8'h5A;
      tick();
      v     = 4'b0100;
      tg[2] = 8'h33;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 4'b0000 || tag !== 8'h5A || out_valid !== 1'b1)
            $display("FAIL bp_hold%0d: got rdy=%b tag=%h v=%b expected rdy=0000 tag=5a v=1",
                     k, in_ready, tag, out_valid);
         else n_pass++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) $display("FAIL bp_release: got %b expected 0100", in_ready);
      else n_pass++;
      tick();
      v = '0;
      n_checks++;
      if (tag !== 8'h33 || opgrp !== NONCOMP)
         $display("FAIL bp_next: got tag=%h o=%0d expected tag=33 o=2", tag, opgrp);
      else n_pass++;
      tick();
   endtask

   task automatic test_flags();
      do_reset();
      out_ready = 1'b1;
      v     = 4'b0001;
      st[0] = 5'b10000;
      tick();
      v     = 4'b0010;
      st[1] = 5'b00001;
      tick();
      v = '0;
      tick();
      n_checks++;
      if (fflags !== 5'b10001) $display("FAIL flags_accum: got %b expected 10001", fflags);
      else n_pass++;
      v     = 4'b0100;
      st[2] = 5'b01000;
      tick();
      v   = '0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++;
      if (fflags !== 5'b01000) $display("FAIL flags_clr_hs: got %b expected 01000", fflags);
      else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b1;
      v     = 4'b0001;
      st[0] = 5'b00100;
      tick();
      v     = 4'b0100;
      flush = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL flush_nogrant: got %b expected 0000", in_ready);
      else n_pass++;
      tick();
      flush = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || fflags !== 5'b00000)
         $display("FAIL flush_drop: got v=%b f=%b expected v=0 f=00000", out_valid, fflags);
      else n_pass++;
      n_checks++;
      if (in_ready !== 4'b0100) $display("FAIL flush_after: got %b expected 0100", in_ready);
      else n_pass++;
      tick();
      v = '0;
      n_checks++;
      if (out_valid !== 1'b1 || opgrp !== NONCOMP)
         $display("FAIL flush_regrant: got v=%b o=%0d expected v=1 o=2", out_valid, opgrp);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1;
      v      = 4'b0010;
      res[1] = 64'hDEAD_BEEF_0000_0001;
      tg[1]  = 8'hC3;
      st[1]  = 5'b00010;
      tick();
      v   = 4'b1111;
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL rstmid_ready: got %b expected 0000", in_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({out_valid, busy, result, status, tag, opgrp, fflags} !== {1'b0, 1'b0, 64'h0, 5'b0, 8'h0, ADDMUL, 5'b0})
         $display("FAIL rstmid_values: got v=%b b=%b r=%h s=%b t=%h o=%0d f=%b expected all zero",
                  out_valid, busy, result, status, tag, opgrp, fflags);
      else n_pass++;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) $display("FAIL rstmid_prio: got %b expected 0001", in_ready);
      else n_pass++;
      tick();
      v = '0;
      tick();
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(19) == 0);
         clr       = ($urandom_range(19) == 0);
         rst       = ($urandom_range(49) == 0);
         for (int i = 0; i < N; i++) begin
            // Producers hold valid and data until their grant.
            if (!v[i] || last_g == i) begin
               v[i]   = ($urandom_range(2) != 0);
               res[i] = {$urandom, $urandom};
               st[i]  = status_t'($urandom_range(31));
               tg[i]  = 8'($urandom);
            end
         end
         #1;
         g = model_grant();
         n_checks++;
         if (in_ready !== ((g < 0) ? 4'b0000 : 4'(1 << g)))
            $display("FAIL rnd_ready c%0d: got %b expected grant %0d", cyc, in_ready, g);
         else n_pass++;
         n_checks++;
         if ({out_valid, busy, fflags, result, status, tag, opgrp} !==
             {m_valid, m_valid, m_fflags, m_result, m_status, m_tag, m_opgrp})
            $display("FAIL rnd_out c%0d: got v=%b b=%b f=%b r=%h s=%b t=%h o=%0d expected v=%b f=%b r=%h s=%b t=%h o=%0d",
                     cyc, out_valid, busy, fflags, result, status, tag, opgrp,
                     m_valid, m_fflags, m_result, m_status, m_tag, m_opgrp);
         else n_pass++;
         tick();
      end
      rst = 1'b0;
      flush = 1'b0;
      clr = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      v         = '0;
      for (int i = 0; i < N; i++) begin
         res[i] = '0;
         st[i]  = '0;
         tg[i]  = '0;
      end
      m_valid  = 0;
      m_result = '0;
      m_status = '0;
      m_tag    = '0;
      m_opgrp  = ADDMUL;
      m_prio   = 0;
      m_fflags = '0;
      #1;
      test_reset();
      test_two_inputs();
      test_fairness();
      test_backpressure();
      test_flags();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
